// File: rtl/vector_controller.sv
// Sequencing controller for the 4 x 512-bit vector register file: accepts one
// instruction at a time and walks it through memory, ALU and write-back phases.
module vector_controller #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              busy,
    output logic [1:0]        rf_rAdd,
    output logic [1:0]        rf_wAdd1,
    output logic [1:0]        rf_wAdd2,
    output logic              rf_wEnable1,
    output logic              rf_wEnable2,
    output logic              rf_src,
    output logic              ld_capture,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              alu_start,
    output logic              alu_op,
    input  logic              alu_done,
    output logic              err,
    output logic [15:0]       retired
);

    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC, S_WB} state_t;

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [15:0]      retired_q, retired_d;

    logic [1:0] opc;
    logic [1:0] rg;

    assign opc = instr_q[15:14];
    assign rg  = instr_q[13:12];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    // Latched instruction is pure data and needs no reset.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        retired_d   = retired_q;
        instr_ready = 1'b0;
        busy        = (state_q != S_IDLE);
        rf_rAdd     = 2'd0;
        rf_wAdd1    = 2'd0;
        rf_wAdd2    = 2'd0;
        rf_wEnable1 = 1'b0;
        rf_wEnable2 = 1'b0;
        rf_src      = 1'b0;
        ld_capture  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        alu_start   = 1'b0;
        alu_op      = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    cnt_d   = '0;
                    state_d = instr[15] ? S_EXEC : S_MEM;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = instr_q[ADDR_W-1:0];
                mem_we   = (opc == OP_STORE);
                rf_rAdd  = (opc == OP_STORE) ? rg : 2'd0;
                if (mem_ack) begin
                    if (opc == OP_STORE) begin
                        state_d   = S_IDLE;
                        retired_d = retired_q + 16'd1;
                    end else begin
                        ld_capture = 1'b1;
                        state_d    = S_WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                // Counter is zero only on the first EXEC cycle, giving a one-cycle start pulse.
                alu_start = (cnt_q == '0);
                alu_op    = opc[0];
                if (alu_done) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_wEnable1 = 1'b1;
                rf_wAdd1    = rg;
                rf_src      = (opc != OP_LOAD);
                if (opc == OP_MUL) begin
                    rf_wEnable2 = 1'b1;
                    rf_wAdd2    = rg + 2'd1;
                end
                state_d   = S_IDLE;
                retired_d = retired_q + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_vector_controller.sv
// Directed-vector bench for vector_controller: table-driven instruction runs
// plus hand-written reset, timeout, ignored-handshake and counter-wrap sequences.
module tb_vector_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        busy;
    logic [1:0]  rf_rAdd, rf_wAdd1, rf_wAdd2;
    logic        rf_wEnable1, rf_wEnable2, rf_src, ld_capture;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic        mem_ack;
    logic        alu_start, alu_op, alu_done;
    logic        err;
    logic [15:0] retired;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_ret;

    always #5 clk = ~clk;

    vector_controller #(.ADDR_W(9), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .busy(busy),
        .rf_rAdd(rf_rAdd), .rf_wAdd1(rf_wAdd1), .rf_wAdd2(rf_wAdd2),
        .rf_wEnable1(rf_wEnable1), .rf_wEnable2(rf_wEnable2),
        .rf_src(rf_src), .ld_capture(ld_capture),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
        .err(err), .retired(retired)
    );

    typedef struct {
        logic [1:0] op;
        logic [1:0] rg;
        logic [8:0] addr;
        int         dly;
        logic       exp_we;
        logic       exp_wb;
        logic       exp_we2;
        logic [1:0] exp_wadd1;
        logic [1:0] exp_wadd2;
        logic       exp_src;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {v.op, v.rg, 3'b101, v.addr};
        #1;
        check("ready_before", instr_ready, 1);
        check("busy_before", busy, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'h0;
        for (int n = 0; n <= v.dly; n++) begin
            if (n > 0) @(negedge clk);
            if (!v.op[1]) mem_ack = (n == v.dly);
            else alu_done = (n == v.dly);
            #1;
            check("busy_wait", busy, 1);
            check("wen1_wait", rf_wEnable1, 0);
            if (!v.op[1]) begin
                check("mem_req", mem_req, 1);
                check("mem_addr", mem_addr, v.addr);
                check("mem_we", mem_we, v.exp_we);
                check("rf_rAdd", rf_rAdd, v.exp_we ? v.rg : 2'd0);
                check("ld_capture", ld_capture, (n == v.dly) && !v.exp_we);
                check("alu_start_mem", alu_start, 0);
            end else begin
                check("alu_start", alu_start, n == 0);
                check("alu_op", alu_op, v.op[0]);
                check("mem_req_exec", mem_req, 0);
            end
        end
        @(negedge clk);
        mem_ack  = 1'b0;
        alu_done = 1'b0;
        #1;
        if (v.exp_wb) begin
            check("wb_wen1", rf_wEnable1, 1);
            check("wb_wadd1", rf_wAdd1, v.exp_wadd1);
            check("wb_src", rf_src, v.exp_src);
            check("wb_wen2", rf_wEnable2, v.exp_we2);
            if (v.exp_we2) check("wb_wadd2", rf_wAdd2, v.exp_wadd2);
            check("wb_mem_req", mem_req, 0);
            check("wb_alu_start", alu_start, 0);
            check("wb_ld_capture", ld_capture, 0);
            check("wb_retired", retired, exp_ret);
            @(negedge clk);
            #1;
        end
        exp_ret = exp_ret + 16'd1;
        check("ready_after", instr_ready, 1);
        check("retired", retired, exp_ret);
        check("wen1_idle", rf_wEnable1, 0);
        check("wen2_idle", rf_wEnable2, 0);
        check("mem_req_idle", mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{2'b00, 2'd2, 9'h1A5, 3, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0};
        vecs[1] = '{2'b01, 2'd1, 9'h003, 0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[2] = '{2'b11, 2'd3, 9'h000, 5, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1};
        vecs[3] = '{2'b10, 2'd0, 9'h055, 0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
        vecs[4] = '{2'b11, 2'd1, 9'h0AA, 0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1};
        vecs[5] = '{2'b00, 2'd3, 9'h000, 0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0};
        vecs[6] = '{2'b01, 2'd2, 9'h1FF, 2, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[7] = '{2'b10, 2'd2, 9'h100, 2, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1};

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        mem_ack     = 1'b0;
        alu_done    = 1'b0;
        exp_ret     = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_alu_start", alu_start, 0);
        reset = 1'b0;

        run(vecs[0]);

        // Reset in the middle of an EXEC that never completes
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h8000;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        check("exec_started", alu_start, 1);
        repeat (2) @(negedge clk);
        #1;
        check("exec_hang_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_ready", instr_ready, 1);
        check("midrst_alu_start", alu_start, 0);
        check("midrst_retired", retired, 0);
        check("midrst_err", err, 0);
        @(negedge clk);
        reset   = 1'b0;
        exp_ret = 16'h0;

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // Handshakes arriving while idle are ignored
        @(negedge clk);
        mem_ack  = 1'b1;
        alu_done = 1'b1;
        @(negedge clk);
        mem_ack  = 1'b0;
        alu_done = 1'b0;
        #1;
        check("stray_busy", busy, 0);
        check("stray_wen1", rf_wEnable1, 0);
        check("stray_retired", retired, exp_ret);

        // Watchdog: LOAD with no ack
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {2'b00, 2'd1, 3'b000, 9'h077};
        @(negedge clk);
        instr_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            check("to_mem_req", mem_req, 1);
            check("to_err_low", err, 0);
        end
        @(negedge clk);
        #1;
        check("to_err", err, 1);
        check("to_ready", instr_ready, 1);
        check("to_mem_req_off", mem_req, 0);
        check("to_no_capture", ld_capture, 0);
        check("to_no_wb", rf_wEnable1, 0);
        check("to_retired", retired, exp_ret);
        @(negedge clk);
        #1;
        check("to_no_late_wb", rf_wEnable1, 0);
        run(vecs[1]);
        check("err_sticky", err, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("err_cleared", err, 0);
        check("retired_cleared", retired, 0);
        exp_ret = 16'h0;

        // Counter wrap from 0xFFFF
        @(negedge clk);
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        release dut.retired_q;
        exp_ret = 16'hFFFF;
        run(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_controller.md
# vector_controller

Sequencing controller for the 4 x 512-bit vector register file. It accepts one 16-bit vector instruction at a time over a valid/ready handshake and steps the register file through each operation:

- read and write addresses and enables,
- the memory request handshake,
- the ALU start/done handshake.

A watchdog aborts hung transactions, and a counter tracks retired instructions. It sits between the instruction source and the register-file/ALU/memory datapath.

## Interface
- ADDR_W, 9: memory word address width (instr[8:0] when 9).
- TIMEOUT, 255: max cycles to wait for mem_ack / alu_done before abort.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept (high only in IDLE).
- instr  in  16  [15:14] opcode, [13:12] reg, [ADDR_W-1:0] address.
- busy  out  1  high in any state other than IDLE.
- rf_rAdd  out  2  register-file read address.
- rf_wAdd1, rf_wAdd2  out  2 each  write addresses.
- rf_wEnable1, rf_wEnable2  out  1 each  write strobes.
- rf_src  out  1  input1 source select: 0 = load buffer, 1 = ALU low result.
- ld_capture  out  1  datapath loads memory read data into load buffer.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  ADDR_W  memory address; valid while mem_req is high.
- mem_ack  in  1  memory completion.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_op  out  1  0 = ADD, 1 = MUL.
- alu_done  in  1  ALU result valid.
- err  out  1  sticky timeout flag; cleared only by reset.
- retired  out  16  count of completed instructions, wraps at 2^16.

## Operation
- Opcodes:
  - 00 LOAD: reg <= mem[addr].
  - 01 STORE: mem[addr] <= reg.
  - 10 ADD: reg <= A1+A2.
  - 11 MUL: reg <= low(A1*A2) and (reg+1) mod 4 <= high(A1*A2).
- States: IDLE, MEM, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr.
  - Go to MEM for opcodes 00 and 01; go to EXEC for 10 and 11.
- MEM:
  - mem_req=1, mem_addr=latched addr, mem_we=(opcode==01).
  - For STORE, rf_rAdd=reg throughout the state.
  - On mem_ack: LOAD asserts ld_capture this cycle and goes to WB; STORE goes to IDLE and retires.
- EXEC:
  - alu_start=1 on the first EXEC cycle only; alu_op=opcode[0].
  - On alu_done, go to WB.
  - A same-cycle alu_done on the start cycle is accepted.
- WB (exactly one cycle):
  - rf_wEnable1=1, rf_wAdd1=reg, rf_src=(opcode!=00).
  - MUL only: also rf_wEnable2=1, rf_wAdd2=reg+1 (2-bit wrap, 3 -> 0).
  - Then go to IDLE and retire.
- Retire: retired increments by 1 on the cycle the FSM leaves for IDLE after a successful instruction.
- Watchdog:
  - An 8-bit-min cycle counter clears on entry to MEM/EXEC and increments each cycle waiting.
  - When it reaches TIMEOUT without ack/done: set err, deassert all strobes, return to IDLE, no retire, no write-back.
- All strobes (mem_req, alu_start, rf_wEnable*, ld_capture) are 0 outside their states.
- rf_rAdd is 0 when not in use.

## Timing
- Reset: FSM=IDLE; instr_ready=1; err=0; retired=0; all other outputs 0. This holds even when reset is asserted mid-MEM or mid-EXEC: mem_req drops the next edge without waiting for ack.
- LOAD with immediate ack:
  - cycle 0: handshake.
  - cycle 1: MEM, mem_req=1, ack, ld_capture.
  - cycle 2: WB.
  - cycle 3: IDLE, ready.
- STORE with immediate ack: cycle 1 MEM; cycle 2 IDLE.
- ADD/MUL with alu_done k cycles after start (k>=0): WB at cycle 2+k, IDLE at cycle 3+k.
- mem_ack or alu_done outside MEM/EXEC is ignored.
- Back-to-back throughput: one instruction accepted per IDLE visit; no overlap.
- mem_addr and mem_we are stable for the full duration of mem_req.

## Test plan
- Reset: assert reset 2 cycles mid-EXEC (alu_done never arrives) -> next cycle IDLE, instr_ready=1, alu_start=0, retired=0, err=0.
- LOAD r2 from 0x1A5, ack after 3 cycles:
  - mem_req high 4 cycles, mem_we=0, mem_addr=0x1A5.
  - ld_capture on the ack cycle.
  - Next cycle rf_wEnable1=1, rf_wAdd1=2, rf_src=0.
  - retired=1.
- STORE r1 to 0x003, immediate ack -> rf_rAdd=1 during MEM, mem_we=1, no rf_wEnable, back to IDLE after 2 cycles.
- MUL r3, alu_done 5 cycles after start:
  - a single alu_start pulse with alu_op=1;
  - in WB, rf_wEnable1=1 with wAdd1=3 and rf_wEnable2=1 with wAdd2=0 (wrap).
- Timeout: LOAD with no mem_ack, TIMEOUT=10 -> err=1 after 10 waiting cycles, return to IDLE, no write, retired unchanged; err stays 1 until reset.
- Counter wrap: preload by running 65536 ADDs (or force) -> retired wraps 0xFFFF -> 0x0000.
